// File: rtl/regfile_pkg.sv
// Shared constants and types for the dual-read register file with busy scoreboard.
// Optional feature macro used by reg_file_sb: REGFILE_BYPASS_EN (write-to-read bypass).
package regfile_pkg;

   localparam int DATA_WIDTH_DEF  = 8;
   localparam int REG_BIT_CNT_DEF = 3;

   // Number of architectural registers addressed by an index of the given width.
   function automatic int reg_count(input int bit_cnt);
      return 1 << bit_cnt;
   endfunction

   typedef logic [DATA_WIDTH_DEF-1:0]  data_t;
   typedef logic [REG_BIT_CNT_DEF-1:0] idx_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Busy scoreboard: one pending-result bit per register, a running count of set
// bits and a one-cycle error pulse for reserving an already-busy register.
// With ZERO_REG set, index 0 is invisible: it never becomes busy or errors.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter  int REG_BIT_CNT = REG_BIT_CNT_DEF,
   parameter  int ZERO_REG    = 0,
   localparam int REG_COUNT   = reg_count(REG_BIT_CNT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [REG_BIT_CNT-1:0] wr_sel,
   input  logic                   rsv_en,
   input  logic [REG_BIT_CNT-1:0] rsv_sel,
   output logic [REG_COUNT-1:0]   busy_vec,
   output logic [REG_BIT_CNT:0]   busy_cnt,
   output logic                   rsv_err
);

   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic                 wr_ok;
   logic                 rsv_ok;
   logic                 cnt_inc;
   logic                 cnt_dec;
   logic [REG_COUNT-1:0] busy_next;
   logic [REG_BIT_CNT:0] cnt_next;
   logic                 err_next;

   // Next busy state: writes clear, reserves set (reserve wins on the same index);
   // the count is tracked incrementally from the same two events.
   always_comb begin
      wr_ok     = wr_en  & ~(ZERO_EN & (wr_sel  == '0));
      rsv_ok    = rsv_en & ~(ZERO_EN & (rsv_sel == '0));
      busy_next = busy_vec;
      if (wr_ok)  busy_next[wr_sel]  = 1'b0;
      if (rsv_ok) busy_next[rsv_sel] = 1'b1;
      cnt_inc   = rsv_ok & ~busy_vec[rsv_sel];
      cnt_dec   = wr_ok & busy_vec[wr_sel] & ~(rsv_ok & (rsv_sel == wr_sel));
      cnt_next  = busy_cnt + {{REG_BIT_CNT{1'b0}}, cnt_inc} - {{REG_BIT_CNT{1'b0}}, cnt_dec};
      err_next  = rsv_ok & busy_vec[rsv_sel] & ~(wr_en & (wr_sel == rsv_sel));
   end

   // Scoreboard state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_vec <= '0;
         busy_cnt <= '0;
         rsv_err  <= 1'b0;
      end else begin
         busy_vec <= busy_next;
         busy_cnt <= cnt_next;
         rsv_err  <= err_next;
      end
   end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one synchronous write port
// and a busy scoreboard that raises stall on read-after-write hazards.
// Optional macro REGFILE_BYPASS_EN: forwards same-cycle write data to the read
// ports and suppresses the stall for a port that hits the bypass.
module reg_file_sb
   import regfile_pkg::*;
#(
   parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter  int REG_BIT_CNT = REG_BIT_CNT_DEF,
   parameter  int ZERO_REG    = 0,
   localparam int REG_COUNT   = reg_count(REG_BIT_CNT)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   wr_en,
   input  logic [REG_BIT_CNT-1:0] wr_sel,
   input  logic [DATA_WIDTH-1:0]  wr_data,
   input  logic                   rsv_en,
   input  logic [REG_BIT_CNT-1:0] rsv_sel,
   input  logic                   rs_a_req,
   input  logic [REG_BIT_CNT-1:0] rs_a_sel,
   input  logic                   rs_b_req,
   input  logic [REG_BIT_CNT-1:0] rs_b_sel,
   output logic [DATA_WIDTH-1:0]  rs_a_data,
   output logic [DATA_WIDTH-1:0]  rs_b_data,
   output logic                   stall,
   output logic [REG_COUNT-1:0]   busy_vec,
   output logic [REG_BIT_CNT:0]   busy_cnt,
   output logic                   rsv_err
);

   localparam bit ZERO_EN = (ZERO_REG != 0);

   logic [DATA_WIDTH-1:0] mem [REG_COUNT];
   logic                  hit_a;
   logic                  hit_b;

   reg_scoreboard #(
      .REG_BIT_CNT (REG_BIT_CNT),
      .ZERO_REG    (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en),
      .wr_sel   (wr_sel),
      .rsv_en   (rsv_en),
      .rsv_sel  (rsv_sel),
      .busy_vec (busy_vec),
      .busy_cnt (busy_cnt),
      .rsv_err  (rsv_err)
   );

   // Register storage; the hardwired zero register never accepts data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en && !(ZERO_EN && (wr_sel == '0))) begin
         mem[wr_sel] <= wr_data;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign hit_a = wr_en & (wr_sel == rs_a_sel) & ~(ZERO_EN & (rs_a_sel == '0));
   assign hit_b = wr_en & (wr_sel == rs_b_sel) & ~(ZERO_EN & (rs_b_sel == '0));
`else
   assign hit_a = 1'b0;
   assign hit_b = 1'b0;
`endif

   // Port A read mux: storage, forced zero for r0, bypassed write data on a hit.
   always_comb begin
      rs_a_data = mem[rs_a_sel];
      if (ZERO_EN && (rs_a_sel == '0)) rs_a_data = '0;
      if (hit_a) rs_a_data = wr_data;
   end

   // Port B read mux, identical to port A.
   always_comb begin
      rs_b_data = mem[rs_b_sel];
      if (ZERO_EN && (rs_b_sel == '0)) rs_b_data = '0;
      if (hit_b) rs_b_data = wr_data;
   end

   // A requested operand whose result is still pending and not forwarded stalls decode.
   assign stall = (rs_a_req & busy_vec[rs_a_sel] & ~hit_a)
                | (rs_b_req & busy_vec[rs_b_sel] & ~hit_b);

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb. Two instances share stimulus: dut (no zero
// register) and dut_z (ZERO_REG=1). Expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_sb;
   import regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [2:0] wr_sel = '0;
   logic [7:0] wr_data = '0;
   logic       rsv_en = 1'b0;
   logic [2:0] rsv_sel = '0;
   logic       rs_a_req = 1'b0;
   logic [2:0] rs_a_sel = '0;
   logic       rs_b_req = 1'b0;
   logic [2:0] rs_b_sel = '0;

   logic [7:0] a_data, b_data, za_data, zb_data;
   logic       stall, z_stall, rsv_err, z_rsv_err;
   logic [7:0] busy_vec, z_busy_vec;
   logic [3:0] busy_cnt, z_busy_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   reg_file_sb #(.DATA_WIDTH(8), .REG_BIT_CNT(3), .ZERO_REG(0)) dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rs_a_req(rs_a_req), .rs_a_sel(rs_a_sel),
      .rs_b_req(rs_b_req), .rs_b_sel(rs_b_sel), .rs_a_data(a_data), .rs_b_data(b_data),
      .stall(stall), .busy_vec(busy_vec), .busy_cnt(busy_cnt), .rsv_err(rsv_err)
   );

   reg_file_sb #(.DATA_WIDTH(8), .REG_BIT_CNT(3), .ZERO_REG(1)) dut_z (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .rsv_en(rsv_en), .rsv_sel(rsv_sel), .rs_a_req(rs_a_req), .rs_a_sel(rs_a_sel),
      .rs_b_req(rs_b_req), .rs_b_sel(rs_b_sel), .rs_a_data(za_data), .rs_b_data(zb_data),
      .stall(z_stall), .busy_vec(z_busy_vec), .busy_cnt(z_busy_cnt), .rsv_err(z_rsv_err)
   );

   // Advance one clock; registered outputs are stable 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 1'b0; rsv_en = 1'b0; rs_a_req = 1'b0; rs_b_req = 1'b0;
   endtask

   task automatic test_reset();
      // load some contents, then reset asynchronously between edges
      rst_n = 1'b1;
      tick();
      wr_en = 1'b1; wr_sel = 3'd1; wr_data = 8'h33; tick();
      wr_sel = 3'd5; wr_data = 8'h44; tick();
      idle(); rsv_en = 1'b1; rsv_sel = 3'd6; tick();
      idle(); rs_a_sel = 3'd1; rs_b_sel = 3'd5;
      #2 rst_n = 1'b0;
      #1;
      $display("reset asserted mid-cycle");
      checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_r1 got %h want 00", a_data); end
      checks++; if (b_data !== 8'h00) begin errors++; $display("FAIL reset_r5 got %h want 00", b_data); end
      checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL reset_busy_vec got %h want 00", busy_vec); end
      checks++; if (busy_cnt !== 4'd0) begin errors++; $display("FAIL reset_busy_cnt got %0d want 0", busy_cnt); end
      checks++; if (rsv_err !== 1'b0) begin errors++; $display("FAIL reset_rsv_err got %b want 0", rsv_err); end
      // a write whose edge arrives during reset must be lost
      tick(); rst_n = 1'b1; tick();
      wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h77;
      #2 rst_n = 1'b0;
      @(posedge clk); #1;
      idle(); rst_n = 1'b1; rs_a_sel = 3'd2;
      #1;
      $display("write r2 <= 77 during reset");
      checks++; if (a_data !== 8'h00) begin errors++; $display("FAIL reset_mid_write got %h want 00", a_data); end
   endtask

   task automatic test_write_read();
      tick();
      wr_en = 1'b1; wr_sel = 3'd3; wr_data = 8'h5A; rs_a_sel = 3'd3; rs_b_sel = 3'd3;
      #1;
      $display("write r3 <= 5a, read r3 on A and B");
      checks++; if (a_data !== (BYP ? 8'h5A : 8'h00)) begin errors++; $display("FAIL wr_same_cycle_a got %h want %h", a_data, BYP ? 8'h5A : 8'h00); end
      checks++; if (b_data !== (BYP ? 8'h5A : 8'h00)) begin errors++; $display("FAIL wr_same_cycle_b got %h want %h", b_data, BYP ? 8'h5A : 8'h00); end
      tick(); idle(); #1;
      checks++; if (a_data !== 8'h5A) begin errors++; $display("FAIL wr_next_cycle_a got %h want 5a", a_data); end
      checks++; if (b_data !== 8'h5A) begin errors++; $display("FAIL wr_next_cycle_b got %h want 5a", b_data); end
   endtask

   task automatic test_stall();
      rsv_en = 1'b1; rsv_sel = 3'd2; rs_a_req = 1'b1; rs_a_sel = 3'd2;
      #1;
      $display("reserve r2, read r2 on A");
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_same_cycle got %b want 0", stall); end
      tick(); rsv_en = 1'b0; #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_pending got %b want 1", stall); end
      checks++; if (busy_cnt !== 4'd1) begin errors++; $display("FAIL stall_busy_cnt got %0d want 1", busy_cnt); end
      checks++; if (busy_vec !== 8'h04) begin errors++; $display("FAIL stall_busy_vec got %h want 04", busy_vec); end
      wr_en = 1'b1; wr_sel = 3'd2; wr_data = 8'h11; #1;
      $display("write r2 <= 11 while reading r2");
      checks++; if (stall !== !BYP) begin errors++; $display("FAIL stall_on_write got %b want %b", stall, !BYP); end
      checks++; if (a_data !== (BYP ? 8'h11 : 8'h00)) begin errors++; $display("FAIL stall_write_data got %h want %h", a_data, BYP ? 8'h11 : 8'h00); end
      tick(); wr_en = 1'b0; #1;
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_after_write got %b want 0", stall); end
      checks++; if (busy_cnt !== 4'd0) begin errors++; $display("FAIL stall_cnt_after got %0d want 0", busy_cnt); end
      checks++; if (a_data !== 8'h11) begin errors++; $display("FAIL stall_r2_value got %h want 11", a_data); end
      idle();
   endtask

   task automatic test_same_edge();
      rsv_en = 1'b1; rsv_sel = 3'd4; wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h22;
      tick(); idle(); rs_b_sel = 3'd4; #1;
      $display("reserve r4 and write r4 <= 22 on one edge");
      checks++; if (busy_vec !== 8'h10) begin errors++; $display("FAIL same_edge_busy got %h want 10", busy_vec); end
      checks++; if (busy_cnt !== 4'd1) begin errors++; $display("FAIL same_edge_cnt got %0d want 1", busy_cnt); end
      checks++; if (rsv_err !== 1'b0) begin errors++; $display("FAIL same_edge_err got %b want 0", rsv_err); end
      checks++; if (b_data !== 8'h22) begin errors++; $display("FAIL same_edge_data got %h want 22", b_data); end
      rsv_en = 1'b1; rsv_sel = 3'd4;
      tick(); idle();
      $display("reserve r4 again");
      checks++; if (rsv_err !== 1'b1) begin errors++; $display("FAIL rsv_err_pulse got %b want 1", rsv_err); end
      checks++; if (busy_cnt !== 4'd1) begin errors++; $display("FAIL rsv_err_cnt got %0d want 1", busy_cnt); end
      checks++; if (busy_vec !== 8'h10) begin errors++; $display("FAIL rsv_err_busy got %h want 10", busy_vec); end
      tick();
      checks++; if (rsv_err !== 1'b0) begin errors++; $display("FAIL rsv_err_one_cycle got %b want 0", rsv_err); end
      wr_en = 1'b1; wr_sel = 3'd4; wr_data = 8'h22; tick(); idle();
      checks++; if (busy_cnt !== 4'd0) begin errors++; $display("FAIL same_edge_cleanup got %0d want 0", busy_cnt); end
   endtask

   task automatic test_zero_reg();
      wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'hFF; tick();
      idle(); rsv_en = 1'b1; rsv_sel = 3'd0; tick();
      idle(); rs_a_req = 1'b1; rs_a_sel = 3'd0; #1;
      $display("write r0 <= ff, reserve r0, read r0");
      checks++; if (za_data !== 8'h00) begin errors++; $display("FAIL zero_read got %h want 00", za_data); end
      checks++; if (z_stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b want 0", z_stall); end
      checks++; if (z_busy_cnt !== 4'd0) begin errors++; $display("FAIL zero_cnt got %0d want 0", z_busy_cnt); end
      checks++; if (z_busy_vec !== 8'h00) begin errors++; $display("FAIL zero_busy got %h want 00", z_busy_vec); end
      checks++; if (a_data !== 8'hFF) begin errors++; $display("FAIL plain_r0_read got %h want ff", a_data); end
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL plain_r0_stall got %b want 1", stall); end
      rsv_en = 1'b1; rsv_sel = 3'd0; tick(); rsv_en = 1'b0;
      $display("reserve r0 again");
      checks++; if (z_rsv_err !== 1'b0) begin errors++; $display("FAIL zero_rsv_err got %b want 0", z_rsv_err); end
      checks++; if (rsv_err !== 1'b1) begin errors++; $display("FAIL plain_rsv_err got %b want 1", rsv_err); end
      wr_en = 1'b1; wr_sel = 3'd0; wr_data = 8'hAB; #1;
      $display("write r0 <= ab while reading r0");
      checks++; if (za_data !== 8'h00) begin errors++; $display("FAIL zero_bypass_read got %h want 00", za_data); end
      checks++; if (stall !== !BYP) begin errors++; $display("FAIL plain_r0_bypass_stall got %b want %b", stall, !BYP); end
      tick(); idle();
      checks++; if (busy_cnt !== 4'd0) begin errors++; $display("FAIL plain_r0_cnt got %0d want 0", busy_cnt); end
      checks++; if (z_rsv_err !== 1'b0) begin errors++; $display("FAIL zero_rsv_err_after got %b want 0", z_rsv_err); end
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         rsv_en = 1'b1; rsv_sel = 3'(i); tick();
         $display("reserve r%0d", i);
         checks++; if (busy_cnt !== 4'(i + 1)) begin errors++; $display("FAIL fill_cnt_%0d got %0d want %0d", i, busy_cnt, i + 1); end
      end
      idle();
      checks++; if (busy_vec !== 8'hFF) begin errors++; $display("FAIL fill_busy_vec got %h want ff", busy_vec); end
      checks++; if (busy_cnt !== 4'd8) begin errors++; $display("FAIL fill_no_wrap got %0d want 8", busy_cnt); end
      checks++; if (z_busy_cnt !== 4'd7) begin errors++; $display("FAIL fill_zero_cnt got %0d want 7", z_busy_cnt); end
      for (int i = 0; i < 8; i++) begin
         wr_en = 1'b1; wr_sel = 3'(i); wr_data = 8'(i * 17); tick();
         $display("write r%0d <= %h", i, 8'(i * 17));
         checks++; if (busy_cnt !== 4'(7 - i)) begin errors++; $display("FAIL drain_cnt_%0d got %0d want %0d", i, busy_cnt, 7 - i); end
      end
      idle(); rs_a_sel = 3'd6; rs_b_sel = 3'd7; #1;
      checks++; if (a_data !== 8'h66) begin errors++; $display("FAIL drain_r6 got %h want 66", a_data); end
      checks++; if (b_data !== 8'h77) begin errors++; $display("FAIL drain_r7 got %h want 77", b_data); end
      checks++; if (busy_vec !== 8'h00) begin errors++; $display("FAIL drain_busy_vec got %h want 00", busy_vec); end
   endtask

   initial begin
      #3;
      test_reset();
      test_write_read();
      test_stall();
      test_same_edge();
      test_zero_reg();
      test_fill();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with two combinational read ports, one synchronous write port, and a per-register busy scoreboard for in-flight results. It replaces the single-port accumulator register file between decode and the ALU. It adds dual operands, an optional hardwired zero register, write-to-read bypass, and a stall output for read-after-write hazards.

## Interface
- DATA_WIDTH, 8, width of each register
- REG_BIT_CNT, 3, register index width; depth = 2^REG_BIT_CNT
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes, never busy
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- wr_en  input  1  write strobe
- wr_sel  input  REG_BIT_CNT  write index
- wr_data  input  DATA_WIDTH  write data
- rsv_en  input  1  reserve request: marks rsv_sel busy (result pending)
- rsv_sel  input  REG_BIT_CNT  reserve index
- rs_a_req / rs_b_req  input  1  port A/B operand actually needed this cycle
- rs_a_sel / rs_b_sel  input  REG_BIT_CNT  read indices
- rs_a_data / rs_b_data  output  DATA_WIDTH  read data, combinational
- stall  output  1  combinational RAW hazard on a requested operand
- busy_vec  output  2^REG_BIT_CNT  registered busy bits
- busy_cnt  output  REG_BIT_CNT+1  registered count of set busy bits
- rsv_err  output  1  registered one-cycle pulse: reserve of an already-busy register

## Operation
- Reset (async, any time, including mid-write or mid-reserve): all registers 0; busy_vec 0; busy_cnt 0; rsv_err 0. Clear loop bound is 2^REG_BIT_CNT, not a literal.
- Write: on posedge with wr_en, reg[wr_sel] <= wr_data and busy[wr_sel] <= 0.
- Reserve: on posedge with rsv_en, busy[rsv_sel] <= 1.
- Same-edge wr_en and rsv_en to the same index: the reserve wins, so the bit stays or becomes set. The data write still happens.
- busy_cnt <= popcount of the next busy_vec. This is implemented incrementally: +1 for a newly set bit, −1 for a cleared set bit, net 0 when both happen.
- rsv_err <= rsv_en & busy[rsv_sel] & ~(wr_en & wr_sel==rsv_sel). The busy bit stays set, busy_cnt is unchanged, and no other effect occurs.
- ZERO_REG=1: writes and reserves to index 0 are dropped (no busy, no rsv_err, no count change). Reads of index 0 return 0 with no hazard.
- Read: rs_x_data = reg[rs_x_sel], or the bypassed value when the bypass is compiled in and hits.
- stall = (rs_a_req & busy[rs_a_sel] & ~hit_a) | (rs_b_req & busy[rs_b_sel] & ~hit_b), where hit_x is the bypass match (0 without the bypass).
- busy_cnt cannot overflow: its width covers 2^REG_BIT_CNT.

## Timing
- Write latency without bypass: data is visible on a read port the cycle after the write edge.
- Write latency with bypass: visible the same cycle as wr_en.
- Reserve latency: busy/stall takes effect the cycle after the rsv_en edge. Decode must not read a register it reserves in the same cycle.
- rsv_err: asserted for exactly one cycle following the offending edge.
- No handshake on writes; the write port is always accepted.

## Configuration
- REGFILE_BYPASS_EN defined: hit_x = wr_en & (wr_sel==rs_x_sel) & ~(ZERO_REG & rs_x_sel==0). On a hit, rs_x_data = wr_data and stall is suppressed for that port.
- REGFILE_BYPASS_EN undefined: reads come from storage only, hit_x = 0, and a pending write stalls until the cycle after it lands.

## Structure
- Package regfile_pkg holds the default DATA_WIDTH and REG_BIT_CNT constants, a derived REG_COUNT function (2^REG_BIT_CNT), and the data/index typedefs.
- Sub-module reg_scoreboard owns busy_vec, busy_cnt, rsv_err and the ZERO_REG filtering. reg_file_sb owns storage, the read muxes, the bypass, and the stall combine.

## Test plan
- Reset with arbitrary contents → all reads 0; busy_vec 0; busy_cnt 0. Assert rst_n mid-write → the write is lost and all registers stay 0.
- Write 0x5A to r3, read r3 on A and r3 on B the same cycle → with bypass both read 0x5A immediately; without bypass both read 0x5A the next cycle.
- rsv r2, then rs_a_req r2 → stall=1 from the next cycle. Write r2=0x11 → stall drops: same cycle with bypass, next cycle without; busy_cnt goes 1→0.
- Same edge: rsv r4 and write r4=0x22 → busy[4]=1, r4=0x22, busy_cnt +1, rsv_err 0. A second rsv r4 → rsv_err pulses for 1 cycle and busy_cnt is unchanged.
- ZERO_REG=1: write r0=0xFF, then rsv r0 → r0 reads 0, never stalls, busy_cnt 0, rsv_err 0.
- Reserve all 2^REG_BIT_CNT registers (ZERO_REG=0) → busy_cnt = 2^REG_BIT_CNT with no wrap; writing each register back → count returns to 0.
